vmul_issue_seq: RTL and testbench

- Operand issue and result-collection stage directly upstream of the 32-bit precision-controlled vector multiplier (mul_32bit_precion_control).
- Accepts multiply requests over a valid/ready handshake and drives the multiplier's registered operand, opcode and precision inputs.
- Tracks in-flight operations through the multiplier's fixed latency and captures each mul_out into a result FIFO.
- Uses credit-based flow control so a result is never dropped, and sequences end-of-vector drain via a last tag.

---
 rtl/vmul_issue_seq.sv | 128 ++++++++++++
 tb/tb_vmul_issue_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmul_issue_seq.sv
// Issue/collect stage in front of the fixed-latency vector multiplier: credit-gated request
// accept, tag pipe aligned to mul_out, FWFT result FIFO, last-tag drain. Optional perf counters: VMUL_ISSUE_PERF_EN.
module vmul_issue_seq #(
  parameter int MUL_LAT   = 3,
  parameter int RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_opcode,
  input  logic [1:0]  req_precision,
  input  logic        req_last,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [1:0]  mul_opcode,
  output logic [1:0]  mul_precision,
  input  logic [31:0] mul_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic        res_err,
  output logic        busy,
`ifdef VMUL_ISSUE_PERF_EN
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
`endif
  output logic        done
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
  typedef struct packed { logic vld; logic last; logic err; } tag_t;
  typedef struct packed { logic [31:0] data; logic last; logic err; } res_t;

  state_e              state_q;
  tag_t [MUL_LAT:0]    tag_pipe_q;
  res_t                mem_q [RES_DEPTH];
  res_t                head;
  logic [CW-1:0]       wptr_q, rptr_q, inflight_q, fifo_cnt, credits;
  logic                accept, pop, fifo_wr, done_q;

  // Credits come only from registered counts, so a same-cycle pop frees nothing until next cycle.
  assign fifo_cnt  = wptr_q - rptr_q;
  assign credits   = CW'(RES_DEPTH) - fifo_cnt - inflight_q;
  assign req_ready = (state_q != DRAIN) && (credits != '0);
  assign accept    = req_valid && req_ready;
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign fifo_wr   = tag_pipe_q[MUL_LAT].vld;
  assign head      = mem_q[rptr_q[AW-1:0]];
  assign res_data  = res_valid ? head.data : '0;
  assign res_last  = res_valid && head.last;
  assign res_err   = res_valid && head.err;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Tail stage lines up with mul_out one edge after the multiplier's MUL_LAT edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_pipe_q    <= '0;
      inflight_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_opcode    <= '0;
      mul_precision <= '0;
    end else begin
      tag_pipe_q[0] <= accept ? '{vld: 1'b1, last: req_last, err: (req_precision == 2'b11)} : '0;
      for (int i = 1; i <= MUL_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      inflight_q <= inflight_q + CW'(accept) - CW'(fifo_wr);
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (accept) begin
        mul_a         <= req_a;
        mul_b         <= req_b;
        mul_opcode    <= req_opcode;
        mul_precision <= (req_precision == 2'b11) ? 2'b10 : req_precision;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem_q[wptr_q[AW-1:0]] <= '{data: tag_pipe_q[MUL_LAT].err ? 32'h0 : mul_out,
                                 last: tag_pipe_q[MUL_LAT].last,
                                 err:  tag_pipe_q[MUL_LAT].err};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:  if (accept) state_q <= req_last ? DRAIN : BUSY;
        BUSY:  if (accept && req_last) state_q <= DRAIN;
               else if (!accept && inflight_q == '0 && fifo_cnt == '0) state_q <= IDLE;
        DRAIN: if (pop && head.last) begin
                 state_q <= IDLE;
                 done_q  <= 1'b1;
               end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VMUL_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && !(&perf_issued_q)) perf_issued_q <= perf_issued_q + 1'b1;
      if (req_valid && !req_ready && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end
  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_vmul_issue_seq.sv
// Bench for vmul_issue_seq: latency-MUL_LAT upper-32 multiplier model, request-order result queue
// model checked every cycle, plus hand-computed literal checks.
module tb_vmul_issue_seq;
  localparam int MUL_LAT   = 3;
  localparam int RES_DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_last = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [1:0]  req_opcode = '0, req_precision = '0;
  logic [31:0] mul_a, mul_b, mul_out;
  logic [1:0]  mul_opcode, mul_precision;
  logic        res_valid, res_ready = 1'b0, res_last, res_err, busy, done;
  logic [31:0] res_data;
`ifdef VMUL_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  vmul_issue_seq #(.MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_precision(req_precision),
    .req_last(req_last), .mul_a(mul_a), .mul_b(mul_b), .mul_opcode(mul_opcode),
    .mul_precision(mul_precision), .mul_out(mul_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_last(res_last), .res_err(res_err),
    .busy(busy),
`ifdef VMUL_ISSUE_PERF_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
    .done(done));

  function automatic logic [31:0] upper(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    return p[63:32];
  endfunction

  // Multiplier stand-in: mul_out reflects mul_* changes MUL_LAT edges later.
  logic [31:0] mpipe [MUL_LAT];
  initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= upper(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[MUL_LAT-1];

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: every accepted request is one queue entry, visible from its write edge
  // until popped; outstanding entries never exceed RES_DEPTH.
  typedef struct { logic [31:0] d; bit last; bit err; int wedge; } exp_t;
  exp_t        q[$];
  int          cyc, m_st, accs, pops;     // m_st: 0 idle, 1 busy, 2 drain
  bit          m_acc, m_done;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_op, m_pr;

  function automatic bit m_ready();
    return (m_st != 2) && (q.size() < RES_DEPTH);
  endfunction
  function automatic bit m_vis();
    return (q.size() > 0) && (q[0].wedge <= cyc);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cyc = 0; m_st = 0; m_acc = 0; m_done = 0;
      m_a = '0; m_b = '0; m_op = '0; m_pr = '0;
    end else begin
      bit acc, pop, plast;
      exp_t e;
      acc   = req_valid && m_ready();
      pop   = res_ready && m_vis();
      plast = 0;
      if (pop) plast = q[0].last;
      m_done = plast && (m_st == 2);
      case (m_st)
        0: if (acc) m_st = req_last ? 2 : 1;
        1: if (acc && req_last) m_st = 2;
           else if (!acc && q.size() == 0) m_st = 0;
        default: if (plast) m_st = 0;
      endcase
      if (dut.fifo_wr) chk("fifo_write_not_full", 32'(dut.fifo_cnt == 3'(RES_DEPTH)), 32'h0);
      if (pop) begin void'(q.pop_front()); pops++; end
      if (acc) begin
        e.err  = (req_precision == 2'b11);
        e.d    = e.err ? 32'h0 : upper(req_a, req_b);
        e.last = req_last;
        e.wedge = cyc + 1 + MUL_LAT + 1;
        q.push_back(e);
        m_a = req_a; m_b = req_b; m_op = req_opcode;
        m_pr = e.err ? 2'b10 : req_precision;
        accs++;
      end
      m_acc = acc;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready()));
      chk("res_valid", 32'(res_valid), 32'(m_vis()));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("mul_opcode", 32'(mul_opcode), 32'(m_op));
      chk("mul_precision", 32'(mul_precision), 32'(m_pr));
      if (m_vis()) begin
        chk("res_data", res_data, q[0].d);
        chk("res_last", 32'(res_last), 32'(q[0].last));
        chk("res_err", 32'(res_err), 32'(q[0].err));
      end
    end
  end

  bit done_seen = 0;
  always @(negedge clk) if (rst && done) done_seen = 1;

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [1:0] pr, input bit last);
    int n = 0;
    req_a = a; req_b = b; req_opcode = op; req_precision = pr; req_last = last;
    req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!m_acc && n < 500);
    if (!m_acc) chk("send_timeout", 32'h0, 32'h1);
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q.size() != 0 || m_st != 0) && n < 1000) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(q.size() == 0 && m_st == 0), 32'h1);
  endtask

  task automatic send_rand(input bit last);
    send($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), last);
  endtask

  int  base_acc, base_pop, wtarget, n;
  bit  rnd_on;

  initial begin
    // reset values
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_mul_a", mul_a, 32'h0);
    chk("rst_mul_prec", 32'(mul_precision), 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single op: accept at edge N, result visible after N+4, done after N+5
    res_ready = 1'b1;
    req_a = 32'h2; req_b = 32'hFFFF_FFFE; req_opcode = 2'b10; req_precision = 2'b10;
    req_last = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("single_busy", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    chk("single_not_yet", 32'(res_valid), 32'h0);
    @(negedge clk);
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_data", res_data, 32'h1);
    chk("single_last", 32'(res_last), 32'h1);
    @(negedge clk);
    chk("single_done", 32'(done), 32'h1);
    chk("single_idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("single_done_pulse", 32'(done), 32'h0);

    // backpressure: 10 requests against a stalled consumer
    res_ready = 1'b0;
    base_acc = accs;
    fork
      begin
        repeat (30) @(negedge clk);
        chk("bp_accepted", 32'(accs - base_acc), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'h0);
        res_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) send_rand(1'b0);
    wait_empty();
    chk("bp_all_accepted", 32'(accs - base_acc), 32'd10);

    // illegal precision between two legal requests
    send(32'h0000_1000, 32'h0010_0000, 2'b01, 2'b10, 1'b0);
    send(32'h1234_5678, 32'h9, 2'b00, 2'b11, 1'b0);
    chk("illegal_mul_prec", 32'(mul_precision), 32'h2);
    send(32'h8000_0000, 32'h6, 2'b11, 2'b10, 1'b0);
    n = 0;
    while (!(res_valid && res_err) && n < 30) begin @(negedge clk); n++; end
    chk("illegal_err", 32'(res_err), 32'h1);
    chk("illegal_data", res_data, 32'h0);
    wait_empty();

    // drain: last on request 3 of 5
    res_ready = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    done_seen = 0;
    send_rand(1'b1);
    chk("drain_state", 32'(busy), 32'h1);
    fork
      begin repeat (15) @(negedge clk); res_ready = 1'b1; end
    join_none
    send_rand(1'b0);
    chk("drain_req4_after_done", 32'(done_seen), 32'h1);
    send_rand(1'b1);
    wait_empty();

    // async reset with 2 in flight and 2 queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    repeat (2) @(negedge clk);
    chk("mid_pre_valid", 32'(res_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    chk("mid_rst_data", res_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    res_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_no_stale", 32'(res_valid), 32'h0);

    // full FIFO, then a pop coinciding with a tag arrival
    res_ready = 1'b0;
    base_acc = accs; base_pop = pops;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    n = 0;
    while (cyc < q[3].wedge && n < 20) begin @(negedge clk); n++; end
    chk("full_ready_low", 32'(req_ready), 32'h0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    send_rand(1'b0);
    wtarget = q[q.size()-1].wedge;
    n = 0;
    while (cyc < wtarget - 1 && n < 20) begin @(negedge clk); n++; end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("fwp_pops", 32'(pops - base_pop), 32'd2);
    chk("fwp_outstanding", 32'(q.size()), 32'd3);
    res_ready = 1'b1;
    wait_empty();
    chk("fwp_total_pops", 32'(pops - base_pop), 32'd5);

    // random traffic with random consumer stalls
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(negedge clk);
        if (rnd_on) res_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 11) == 0));
    end
    rnd_on = 0;
    repeat (2) @(negedge clk);
    res_ready = 1'b1;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
